// File: rtl/pipeline_skid_stage_pkg.sv
// Shared pipeline definitions: stage state encoding {main valid, skid valid}
// and the zero payload presented by empty slots.
package pipeline_skid_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b10,
    ST_SKID  = 2'b11
  } stage_state_e;

  localparam int unsigned MAX_PAYLOAD_WIDTH = 1024;
  localparam logic [MAX_PAYLOAD_WIDTH-1:0] ZERO_PAYLOAD = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != COUNT_MAX)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_skid_stage.sv
// Elastic pipeline register with a 2-entry skid buffer: registered in_ready,
// zeroed payload on empty slots, and a saturating back-pressure counter.
module pipeline_skid_stage
  import pipeline_skid_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_wb,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_wb,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = ZERO_PAYLOAD[DATA_WIDTH-1:0];

  stage_state_e          state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  main_wb_q, main_wb_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic                  skid_wb_q, skid_wb_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  accept;
  logic                  consume;

  assign accept  = in_valid & in_ready_q;
  assign consume = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      main_wb_q   <= 1'b0;
      main_data_q <= '0;
      skid_wb_q   <= 1'b0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_wb_q   <= main_wb_d;
      main_data_q <= main_data_d;
      skid_wb_q   <= skid_wb_d;
      skid_data_q <= skid_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_FULL;
        ST_FULL: begin
          if (accept && !consume) state_d = ST_SKID;
          else if (!accept && consume) state_d = ST_EMPTY;
        end
        ST_SKID: if (consume) state_d = ST_FULL;
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // in_data is only ever copied on accept, so idle junk never reaches out_data.
  always_comb begin
    main_wb_d   = main_wb_q;
    main_data_d = main_data_q;
    skid_wb_d   = skid_wb_q;
    skid_data_d = skid_data_q;
    in_ready_d  = (state_d != ST_SKID);
    if (flush) begin
      main_wb_d   = 1'b0;
      main_data_d = ZERO_DATA;
      skid_wb_d   = 1'b0;
      skid_data_d = ZERO_DATA;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_wb_d   = in_wb;
            main_data_d = in_data;
          end
        end
        ST_FULL: begin
          if (accept && consume) begin
            main_wb_d   = in_wb;
            main_data_d = in_data;
          end else if (accept) begin
            skid_wb_d   = in_wb;
            skid_data_d = in_data;
          end else if (consume) begin
            main_wb_d   = 1'b0;
            main_data_d = ZERO_DATA;
          end
        end
        ST_SKID: begin
          if (consume) begin
            main_wb_d   = skid_wb_q;
            main_data_d = skid_data_q;
            skid_wb_d   = 1'b0;
            skid_data_d = ZERO_DATA;
          end
        end
        default: begin
          main_wb_d   = 1'b0;
          main_data_d = ZERO_DATA;
          skid_wb_d   = 1'b0;
          skid_data_d = ZERO_DATA;
        end
      endcase
    end
  end

  always_comb begin
    in_ready  = in_ready_q;
    out_valid = (state_q != ST_EMPTY);
    out_wb    = main_wb_q;
    out_data  = main_data_q;
  end

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (out_valid & ~out_ready),
    .count(stall_count)
  );

endmodule

// File: doc/pipeline_skid_stage.md
Name: pipeline_skid_stage

Overview:
- Generic elastic pipeline register that replaces the fixed stall/flush stage registers (e.g. MEM→WB) with a valid/ready handshake and a 2-entry skid buffer.
- Upstream sees a registered ready, so no combinational ready path crosses the stage.
- Carries a write-back enable bit plus a parametrised payload.
- Bubbles always present as zero payload with write-back disabled.
- Includes a saturating back-pressure cycle counter for performance debug.

Parameters:
- DATA_WIDTH, 32, payload width in bits (≥1).
- CNT_WIDTH, 16, width of the stall cycle counter (≥1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous flush; discards all held entries.
- in_valid  input  1  upstream offers an entry.
- in_ready  output  1  stage accepts an entry this cycle; registered.
- in_wb  input  1  write-back enable of the offered entry.
- in_data  input  DATA_WIDTH  payload of the offered entry.
- out_valid  output  1  stage presents an entry.
- out_ready  input  1  downstream accepts the presented entry.
- out_wb  output  1  write-back enable of the presented entry; 0 when out_valid=0.
- out_data  output  DATA_WIDTH  payload of the presented entry; 0 when out_valid=0.
- stall_count  output  CNT_WIDTH  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Reset (async, rst_n=0): all state clears immediately.
  - out_valid=0, out_wb=0, out_data=0.
  - in_ready=1.
  - stall_count=0.
  - Skid slot empty.
  - Reset mid-transfer drops all entries.
- Storage: main slot drives the out_* ports directly from flops. The skid slot holds one overflow entry.
- Transfer definitions:
  - accept = in_valid & in_ready.
  - consume = out_valid & out_ready.
- State machine, 3 states encoded by {main valid, skid valid}:
  - EMPTY (0,0):
    - accept → FULL, main loads in_*.
    - Otherwise stay.
  - FULL (1,0):
    - accept & consume → FULL, main loads in_*.
    - accept & !consume → SKID, skid loads in_*.
    - !accept & consume → EMPTY, main zeroed.
    - Neither → hold.
  - SKID (1,1), where in_ready=0 so accept is impossible:
    - consume → FULL, main loads skid contents, skid cleared.
    - Otherwise hold.
- in_ready = !skid valid, registered. It is 1 in EMPTY and FULL, and 0 in SKID.
- Latency and throughput:
  - Latency is 1 cycle: an entry accepted in cycle N appears on out_* in cycle N+1.
  - Sustained throughput is 1 entry/cycle with out_ready held at 1.
  - Entries leave strictly in acceptance order. No entry is lost or duplicated.
- Flush: synchronous and highest priority over accept and consume.
  - Next state is EMPTY, main and skid are zeroed, and in_ready=1.
  - An entry offered in the flush cycle is discarded, even if in_ready was 1.
  - Downstream must ignore a consume in the flush cycle. The entry is still presented that cycle, but the stage does not count it as lost.
- Empty-slot data rule: whenever main becomes empty, out_wb and out_data are driven 0. Downstream may therefore use out_wb without gating by out_valid.
- Stall count:
  - Increments by 1 on every cycle with out_valid=1 and out_ready=0, including flush cycles.
  - Saturates at 2^CNT_WIDTH−1; no wrap-around.
  - Cleared only by reset.
- Input stability: the stage imposes no requirement on in_* when in_valid=0. X on in_data must not propagate into out_data unless the entry is accepted.

Decomposition:
- Shared pipeline package: state encoding constants (ST_EMPTY, ST_FULL, ST_SKID) and a zero-payload constant. Other pipeline stages reuse these.
- One natural sub-module: sat_counter (parametrised width, enable, async active-low reset). It implements stall_count and is reusable for other performance counters.
- Everything else stays inline.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release, in_valid=0 for 5 cycles → out_valid=0, out_data=0, out_wb=0, in_ready=1, stall_count=0 throughout.
- Streaming: out_ready=1, send 0x11, 0x22, 0x33 with wb=1 on consecutive cycles → out_data equals 0x11, 0x22, 0x33 on cycles 1–3 after the first accept, in_ready stays 1, stall_count stays 0.
- Back-pressure/skid: out_ready=0, send 0xA and 0xB back-to-back → in_ready=0 after the second accept, 0xC is held off, stall_count increments each cycle. Raise out_ready → outputs are 0xA, then 0xB, then 0xC in order with no loss.
- Flush during SKID: with 0xA and 0xB held, assert flush together with in_valid=1, in_data=0xC → next cycle out_valid=0, out_data=0, out_wb=0, in_ready=1, and 0xC never appears.
- Saturation: CNT_WIDTH=3, hold out_valid=1 and out_ready=0 for 10 cycles → stall_count reads 7 and stays at 7.
- Async reset mid-operation: drop rst_n between clock edges while in SKID → all outputs are at reset values before the next clock edge, and no stale entries remain after release.
